// File: rtl/pipelined_add_if.sv
// rtl/pipelined_add_if.sv - valid/ready operand and result bundle for pipelined_add
interface pipelined_add_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, out, carry
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, out, carry
    );
endinterface

// File: rtl/pipelined_add.sv
// rtl/pipelined_add.sv - pipelined unsigned adder with valid/ready, bubble collapsing and carry-out
// Optional clamp to all-ones on carry when PIPELINED_ADD_SAT_EN is defined.
module pipelined_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    pipelined_add_if.slave bus
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  x_d;
    logic [WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]  y_d;
    logic [WIDTH:0]    d_q [1:STAGES-1];
    logic [WIDTH:0]    d_d [1:STAGES-1];
    logic [WIDTH:0]    sum;

    // A stage may move whenever it is empty or its successor moves, so holes close up under stall.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = bus.out_ready | ~v_q[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~v_q[i] | adv[i+1];
        end
    end

    always_comb begin
        sum = {1'b0, x_q} + {1'b0, y_q};
`ifdef PIPELINED_ADD_SAT_EN
        if (sum[WIDTH]) begin
            sum[WIDTH-1:0] = '1;
        end
`endif
    end

    always_comb begin
        v_d = v_q;
        x_d = x_q;
        y_d = y_q;
        d_d = d_q;
        if (adv[0]) begin
            v_d[0] = bus.in_valid;
            x_d    = bus.x;
            y_d    = bus.y;
        end
        if (adv[1]) begin
            v_d[1] = v_q[0];
            d_d[1] = sum;
        end
        for (int i = 2; i < STAGES; i++) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                d_d[i] = d_q[i-1];
            end
        end
    end

    // Only the valid bits and the output stage are cleared; inner data is don't-care while invalid.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
        for (int i = 1; i < STAGES - 1; i++) begin
            d_q[i] <= d_d[i];
        end
        if (rst) begin
            v_q           <= '0;
            d_q[STAGES-1] <= '0;
        end else begin
            v_q           <= v_d;
            d_q[STAGES-1] <= d_d[STAGES-1];
        end
    end

    assign bus.in_ready  = adv[0] & ~rst;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out       = d_q[STAGES-1][WIDTH-1:0];
    assign bus.carry     = d_q[STAGES-1][WIDTH];

endmodule

// File: tb/tb_pipelined_add.sv
// tb/tb_pipelined_add.sv - directed vector and sequence bench for pipelined_add
module tb_pipelined_add;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
`ifdef PIPELINED_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wrap;
        logic        c;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipelined_add_if #(.WIDTH(WIDTH)) bus ();

    pipelined_add #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT && s[32]) s[31:0] = '1;
        return s;
    endfunction

    // Scoreboard: every accepted pair must come out once, in order, and hold while stalled.
    logic [32:0] sb[$];
    logic        stall = 1'b0;
    logic [32:0] held;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            sb.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", {bus.carry, bus.out}, held);
            end
            stall = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %0h expected none", {bus.carry, bus.out});
                    end else begin
                        check("order", {bus.carry, bus.out}, sb.pop_front());
                    end
                end else begin
                    stall = 1'b1;
                    held  = {bus.carry, bus.out};
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.x, bus.y));
        end
    end

    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eo, input logic ec, input string nm);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = a;
        bus.y         = b;
        #1 check({nm, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x        = $urandom;
        bus.y        = $urandom;
        #1 check({nm, "_early"}, bus.out_valid, 0);
        repeat (STAGES - 1) @(negedge clk);
        #1;
        check({nm, "_valid"}, bus.out_valid, 1);
        check({nm, "_out"}, bus.out, eo);
        check({nm, "_carry"}, bus.carry, ec);
        @(negedge clk);
        #1 check({nm, "_one_cycle"}, bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        logic [31:0] exp_out;
        int          got;
        int          acc;
        logic [31:0] bub_exp[3];

        vecs[0] = '{32'd3,         32'd5,         32'd8,         1'b0, "basic"};
        vecs[1] = '{32'd0,         32'd0,         32'd0,         1'b0, "zero"};
        vecs[2] = '{32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1'b1, "ovf_plus2"};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, "ovf_exact"};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "msb_pair"};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, "mixed"};
        vecs[6] = '{32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFF, 1'b0, "max_no_carry"};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "all_ones"};
        vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, "half_max"};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_carry", bus.carry, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            exp_out = (SAT && vecs[i].c) ? 32'hFFFF_FFFF : vecs[i].wrap;
            send_one(vecs[i].a, vecs[i].b, exp_out, vecs[i].c, vecs[i].name);
        end

        // Streaming: 16 back-to-back pairs (i, 2i), results must be contiguous.
        got = 0;
        for (int c = 0; c < STAGES + 20; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (c < 16);
            bus.x         = c;
            bus.y         = 2 * c;
            #1;
            if (c < 16) check("stream_in_ready", bus.in_ready, 1);
            if (bus.out_valid) begin
                check("stream_out", bus.out, 3 * got);
                check("stream_cycle", c, STAGES + got);
                got++;
            end
        end
        check("stream_count", got, 16);

        // Backpressure: stall the consumer, the pipeline fills to exactly STAGES entries.
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.x         = 100 + acc;
            bus.y         = acc;
            #1;
            if (bus.in_ready) acc++;
        end
        check("bp_accepts", acc, STAGES);
        check("bp_head_valid", bus.out_valid, 1);
        check("bp_head_out", bus.out, 100);
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (acc < 6);
            bus.x         = 100 + acc;
            bus.y         = acc;
            #1;
            if (bus.out_valid) begin
                check("bp_drain_out", bus.out, 100 + 2 * got);
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        check("bp_drain_count", got, 6);

        // Bubble collapse: head stalls but the two following pairs still get in.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = 7;
        bus.y         = 1;
        #1 check("bub_a_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.x         = 8;
        bus.y         = 2;
        #1 check("bub_b_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.x = 9;
        bus.y = 3;
        #1 check("bub_c_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("bub_full_ready", bus.in_ready, 0);
        check("bub_head_valid", bus.out_valid, 1);
        check("bub_head_out", bus.out, 8);
        bub_exp[0] = 8;
        bub_exp[1] = 10;
        bub_exp[2] = 12;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && got < 3) begin
                check("bub_drain_out", bus.out, bub_exp[got]);
                got++;
            end
        end
        check("bub_drain_count", got, 3);

        // Reset with two results in flight, plus a simultaneous offered transfer.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.x         = 1000;
        bus.y         = 1;
        #1 check("rmf_a_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.x = 2000;
        bus.y = 2;
        #1 check("rmf_b_ready", bus.in_ready, 1);
        @(negedge clk);
        rst   = 1'b1;
        bus.x = 3000;
        bus.y = 3;
        #1 check("rmf_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rmf_out_valid", bus.out_valid, 0);
        check("rmf_out", bus.out, 0);
        check("rmf_carry", bus.carry, 0);
        check("rmf_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 check("rmf_no_stale", bus.out_valid, 0);
        end
        send_one(32'd1, 32'd1, 32'd2, 1'b0, "rmf_after");

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_add.md
# pipelined_add

Parametrised, fully pipelined two-operand unsigned adder with a valid/ready handshake on both sides, per-stage bubble collapsing, and a carry-out. It generalises the fixed two-cycle 32-bit adder pipeline with configurable operand width and pipeline depth, backpressure, and optional saturation. It sits between arithmetic producers and consumers in the generated datapath wherever an adder must tolerate a stalling consumer.

## Interface
- WIDTH, 32, operand and result width in bits; legal range ≥1.
- STAGES, 2, register stages from input to output; legal range ≥2. This is also the latency in cycles.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  x/y hold a valid operand pair.
- in_ready  output  1  pipeline accepts the pair this cycle.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- out_valid  output  1  out/carry hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  sum; wraps modulo 2^WIDTH, or saturates (see Configuration).
- carry  output  1  carry-out of the WIDTH-bit add; always the true carry, regardless of saturation.

## Operation
- Each stage i (0..STAGES-1) has a valid bit v[i] and data registers.
- Stage 0 captures x and y.
- The add is computed combinationally from stage 0's registers and captured into stage 1 as a WIDTH+1-bit {carry, sum}.
- Stages 2..STAGES-1 are pure delay.
- Advance rules:
  - Stage STAGES-1 advances when out_ready is 1 or v[STAGES-1] is 0.
  - Stage i < STAGES-1 advances when v[i] is 0 or stage i+1 advances (bubble collapsing).
  - A stage that advances loads its predecessor's valid and data; stage 0 loads in_valid, x and y.
  - A stage that does not advance holds its contents.
- Handshake:
  - in_ready equals the stage-0 advance condition, gated low during rst.
  - A transfer occurs when in_valid and in_ready are both 1 on a clk edge.
  - A result is consumed when out_valid and out_ready are both 1.
  - The producer may change x/y freely when in_valid is 0.
  - out/carry are stable while out_valid=1 and out_ready=0.
- Ordering: results leave in acceptance order, with no drops or duplicates.
- Throughput: one result per cycle while out_ready is held at 1.
- Width rule: {carry, out_raw} = x + y computed at WIDTH+1 bits; out_raw = low WIDTH bits.
- Reset:
  - All v[i] clear to 0.
  - Final-stage data clears: out=0, carry=0.
  - Earlier data registers are not reset.
  - Reset mid-operation discards all in-flight results. The cycle after rst deasserts, out_valid=0 and in_ready=1.

## Timing
- Latency: a pair accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles through the registers. For STAGES=2: accept at edge 0, result visible after edge 1.
- in_ready is combinational from out_ready and v[]. There is no combinational path from in_valid, x or y to any output.
- Reset values, observed in the cycle after rst is sampled high: out_valid=0, out=0, carry=0, in_ready=0 while rst=1.
- Full pipeline with out_ready=0: in_ready=0 and no state changes.
- Full pipeline with out_ready=1: accept and emit in the same cycle.
- Simultaneous rst and transfer: rst wins; the input is dropped and no result is produced.

## Configuration
- PIPELINED_ADD_SAT_EN defined: when carry=1 for a result, out presents all-ones ({WIDTH{1'b1}}) instead of the wrapped sum. The clamp is applied at stage 1 capture, so it adds no latency. carry still reports the true carry.
- PIPELINED_ADD_SAT_EN undefined: out is the wrapped sum modulo 2^WIDTH, and no saturation logic is present.

## Test plan
- Basic, defaults, out_ready=1: accept x=3, y=5 → after STAGES=2 cycles, out_valid=1, out=8, carry=0 for exactly one cycle.
- Overflow, WIDTH=32: accept x=0xFFFF_FFFF, y=2 → out=0x0000_0001 and carry=1 without the macro; out=0xFFFF_FFFF and carry=1 with PIPELINED_ADD_SAT_EN.
- Streaming, STAGES=4: drive 16 back-to-back pairs (i, 2i) with out_ready=1 → 16 results 3i, in order, contiguous, with the first appearing 4 cycles after the first accept.
- Backpressure, STAGES=3: out_ready=0 while streaming → in_ready drops after 3 accepts and out holds the first sum. Then raise out_ready → remaining results drain in order with no loss.
- Bubble collapse: one pair accepted, then out_ready=0, then 2 more pairs offered → both are accepted while the head result is held (no premature in_ready=0).
- Reset mid-flight: assert rst for one cycle with 2 results in flight → out_valid=0, out=0 next cycle; no stale results ever emerge; the next accepted 1+1 yields 2.
